// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Two-master / one-slave Wishbone classic round-robin arbiter.
//               Optional burst-length preemption: WB_ARB_BURST_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 64
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic [DW-1:0]   m0_dat_r,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic [DW-1:0]   m1_dat_r,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_dat_r,
    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t fsm_q, fsm_d;
    logic   last_q, last_d;
    logic   w_revoke;

`ifdef WB_ARB_BURST_LIMIT_EN
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    logic [CW-1:0] ack_cnt_q, ack_cnt_d;

    // Preempt only once the burst budget is spent and the other master waits.
    always_comb begin
        w_revoke = 1'b0;
        if ((MAX_BURST > 0) && (ack_cnt_q == CW'(MAX_BURST))) begin
            case (fsm_q)
                GNT0:    w_revoke = m1_cyc;
                GNT1:    w_revoke = m0_cyc;
                default: w_revoke = 1'b0;
            endcase
        end
    end

    always_comb begin
        ack_cnt_d = ack_cnt_q;
        if (fsm_d != fsm_q) begin
            ack_cnt_d = '0;
        end else if ((m0_ack || m1_ack) && (ack_cnt_q != CW'(MAX_BURST))) begin
            ack_cnt_d = ack_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_cnt_q <= '0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
        end
    end
`else
    assign w_revoke = 1'b0;
`endif

    always_comb begin
        fsm_d  = fsm_q;
        last_d = last_q;
        case (fsm_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    fsm_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    fsm_d = GNT0;
                end else if (m1_cyc) begin
                    fsm_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    fsm_d = m1_cyc ? GNT1 : IDLE;
                end else if (w_revoke) begin
                    fsm_d = GNT1;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    fsm_d = m0_cyc ? GNT0 : IDLE;
                end else if (w_revoke) begin
                    fsm_d = GNT0;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (fsm_d == GNT0) begin
            last_d = 1'b0;
        end else if (fsm_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm_q  <= IDLE;
            last_q <= 1'b1;
        end else begin
            fsm_q  <= fsm_d;
            last_q <= last_d;
        end
    end

    // Slave-side mux; cyc/stb are masked during a preemption cycle.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        gnt     = 2'b00;
        case (fsm_q)
            GNT0: begin
                s_cyc   = m0_cyc & ~w_revoke;
                s_stb   = m0_stb & ~w_revoke;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                gnt     = 2'b01;
            end
            GNT1: begin
                s_cyc   = m1_cyc & ~w_revoke;
                s_stb   = m1_stb & ~w_revoke;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                gnt     = 2'b10;
            end
            default: ;
        endcase
    end

    // Acks reach the granted master only, and only while its cycle is live.
    always_comb begin
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_dat_r = s_dat_r;
        m1_dat_r = s_dat_r;
        case (fsm_q)
            GNT0:    m0_ack = s_ack & m0_cyc & ~w_revoke;
            GNT1:    m1_ack = s_ack & m1_cyc & ~w_revoke;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Scoreboard bench for wb_rr_arbiter (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MB = 4;

    typedef struct {
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    mcyc, mstb, mwe, mack;
    logic [AW-1:0] madr  [2];
    logic [DW-1:0] mdatw [2];
    logic [SW-1:0] msel  [2];
    logic [DW-1:0] mdatr [2];

    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic [SW-1:0] s_sel;
    logic [1:0]    gnt;
    logic          force_ack;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q0 [$];
    exp_t       exp_q1 [$];
    logic [1:0] glog   [$];
    logic [1:0] gnt_prev;

    // Zero-wait slave; address 0x200 holds a fixed pattern, elsewhere ~adr.
    assign s_ack   = (s_cyc & s_stb) | force_ack;
    assign s_dat_r = (s_adr == 32'h200) ? 32'hDEADBEEF : ~s_adr;

    wb_rr_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .nrst(nrst),
        .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
        .m0_dat_w(mdatw[0]), .m0_sel(msel[0]), .m0_ack(mack[0]), .m0_dat_r(mdatr[0]),
        .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
        .m1_dat_w(mdatw[1]), .m1_sel(msel[1]), .m1_ack(mack[1]), .m1_dat_r(mdatr[1]),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
        .gnt(gnt)
    );

    function automatic logic [31:0] exp_data(input logic [31:0] adr);
        return (adr == 32'h200) ? 32'hDEADBEEF : ~adr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mon_ack(input int id);
        exp_t e;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL m%0d_unexpected_ack: got ack with gnt=%b, none expected", id, gnt);
        end else begin
            e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("m%0d_ack_gnt", id), 32'(gnt), (id == 0) ? 32'h1 : 32'h2);
            if (e.chk) check($sformatf("m%0d_dat_r", id), mdatr[id], e.dat);
        end
    endtask

    // Monitor: logs grant changes and scores every delivered ack.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt !== gnt_prev) begin
                glog.push_back(gnt);
                gnt_prev = gnt;
            end
            if (mack[0]) mon_ack(0);
            if (mack[1]) mon_ack(1);
        end
    end

    task automatic master(input int id, input logic [31:0] adr, input int n, input logic we);
        int   cnt   = 0;
        int   guard = 0;
        logic a;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.chk = ~we;
            e.dat = exp_data(adr + 32'(4 * i));
            if (id == 0) exp_q0.push_back(e);
            else         exp_q1.push_back(e);
        end
        mcyc[id]  = 1'b1;
        mstb[id]  = 1'b1;
        mwe[id]   = we;
        madr[id]  = adr;
        mdatw[id] = adr ^ 32'h5A5A0000;
        msel[id]  = 4'hF;
        while (cnt < n && guard < 200) begin
            @(negedge clk);
            a = mack[id];
            @(posedge clk);
            #1;
            guard++;
            if (a) begin
                cnt++;
                madr[id] = madr[id] + 32'd4;
            end
        end
        check($sformatf("m%0d_ack_count", id), 32'(cnt), 32'(n));
        mcyc[id] = 1'b0;
        mstb[id] = 1'b0;
        mwe[id]  = 1'b0;
    endtask

    task automatic clear_log();
        glog.delete();
        gnt_prev = gnt;
    endtask

    task automatic check_log(input string name, input logic [15:0] seq, input int n);
        check({name, "_len"}, 32'(glog.size()), 32'(n));
        for (int i = 0; i < n && i < glog.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 32'(glog[i]), 32'(seq[2*i +: 2]));
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mcyc = '0; mstb = '0; mwe = '0; force_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            madr[i] = '0; mdatw[i] = '0; msel[i] = '0;
        end
        gnt_prev = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_s_cyc", 32'(s_cyc), 32'h0);
        check("rst_s_stb", 32'(s_stb), 32'h0);
        check("rst_acks",  32'(mack),  32'h0);
        check("rst_s_adr", s_adr,      32'h0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;

        // m0 alone: one-cycle latency, passthrough, stray ack suppression
        clear_log();
        fork
            master(0, 32'h100, 3, 1'b0);
            begin
                @(negedge clk);
                check("t1_lat_gnt", 32'(gnt), 32'h0);
                @(negedge clk);
                check("t1_gnt",   32'(gnt),   32'h1);
                check("t1_s_adr", s_adr,      32'h100);
                check("t1_s_cyc", 32'(s_cyc), 32'h1);
            end
        join
        force_ack = 1'b1;
        @(negedge clk);
        check("t1_drop_gnt",   32'(gnt),   32'h1);
        check("t1_drop_s_cyc", 32'(s_cyc), 32'h0);
        check("t1_stray_ack",  32'(mack),  32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_idle_gnt", 32'(gnt),  32'h0);
        check("t1_idle_ack", 32'(mack), 32'h0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        check_log("t1_log", {12'h0, 2'b00, 2'b01}, 2);

        // Simultaneous request after reset: m0 first, then m1 without bubble
        do_reset();
        clear_log();
        fork
            master(0, 32'h300, 2, 1'b0);
            master(1, 32'h400, 2, 1'b0);
        join
        settle();
        check_log("t2_log", {10'h0, 2'b00, 2'b10, 2'b01}, 3);

        // Continuous contention, 4 acks per cycle: strict alternation
        clear_log();
        fork
            begin
                master(0, 32'h1000, 4, 1'b0);
                @(posedge clk);
                #1 master(0, 32'h1100, 4, 1'b0);
            end
            begin
                master(1, 32'h2000, 4, 1'b0);
                @(posedge clk);
                #1 master(1, 32'h2100, 4, 1'b0);
            end
        join
        settle();
        check_log("t3_log", {6'h0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01}, 5);

        // m1 read of the fixed pattern, then an m1 write
        fork
            master(1, 32'h200, 1, 1'b0);
            begin
                repeat (2) @(negedge clk);
                check("t4_rd_s_we", 32'(s_we), 32'h0);
                check("t4_rd_gnt",  32'(gnt),  32'h2);
            end
        join
        settle();
        fork
            master(1, 32'h600, 1, 1'b1);
            begin
                repeat (2) @(negedge clk);
                check("t4_wr_s_we",    32'(s_we),  32'h1);
                check("t4_wr_s_dat_w", s_dat_w,    32'h5A5A0600);
                check("t4_wr_s_sel",   32'(s_sel), 32'hF);
            end
        join
        settle();

        // Asynchronous reset in the middle of an m1 burst
        clear_log();
        fork
            master(1, 32'h500, 5, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #2 check("t5_pre_s_cyc", 32'(s_cyc), 32'h1);
                nrst = 1'b0;
                #1;
                check("t5_rst_s_cyc", 32'(s_cyc), 32'h0);
                check("t5_rst_gnt",   32'(gnt),   32'h0);
                check("t5_rst_ack",   32'(mack),  32'h0);
                @(posedge clk);
                #3 nrst = 1'b1;
            end
        join
        settle();
        check_log("t5_log", {8'h0, 2'b00, 2'b10, 2'b00, 2'b10}, 4);

        // m0 streams while m1 waits: burst limit preempts after MB acks
        clear_log();
        fork
            master(0, 32'h700, 6, 1'b0);
            begin
                @(posedge clk);
                #1 master(1, 32'h800, 2, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
`ifdef WB_ARB_BURST_LIMIT_EN
                check("t6_revoke_s_cyc", 32'(s_cyc), 32'h0);
                check("t6_revoke_gnt",   32'(gnt),   32'h1);
                @(negedge clk);
                check("t6_after_gnt",    32'(gnt),   32'h2);
`else
                check("t6_hold_s_cyc",   32'(s_cyc), 32'h1);
                check("t6_hold_gnt",     32'(gnt),   32'h1);
                @(negedge clk);
                check("t6_after_gnt",    32'(gnt),   32'h1);
`endif
            end
        join
        settle();
`ifdef WB_ARB_BURST_LIMIT_EN
        check_log("t6_log", {8'h0, 2'b00, 2'b01, 2'b10, 2'b01}, 4);
`else
        check_log("t6_log", {10'h0, 2'b00, 2'b10, 2'b01}, 3);
`endif

        check("sb_q0_empty", 32'(exp_q0.size()), 32'h0);
        check("sb_q1_empty", 32'(exp_q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
